// File: rtl/ram_io_responder.sv
// Responder for the memory_controller byte port: 1-cycle-latency RAM, a UART
// data register backed by TX/RX FIFOs, and a write-triggered halt strobe.
module ram_io_responder #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter logic [31:0] IO_ADDR     = 32'h0003_0000,
  parameter logic [31:0] HALT_ADDR   = 32'h0003_0004,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        sim_halt
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned RAM_SIZE = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(FULL_MARGIN);

  logic [7:0] mem [RAM_SIZE];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0] tx_count, rx_count, tx_count_next, rx_count_next;

  logic                  io_sel, halt_sel, ram_sel;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  tx_push, tx_pop, rx_push, rx_pop;

  // Address decode: anything outside the two I/O registers aliases into RAM.
  assign io_sel   = (mem_a == IO_ADDR);
  assign halt_sel = (mem_a == HALT_ADDR);
  assign ram_sel  = !io_sel && !halt_sel;
  assign ram_a    = mem_a[ADDR_WIDTH-1:0];

  assign tx_full  = (tx_count == DEPTH_C);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == DEPTH_C);
  assign rx_empty = (rx_count == '0);

  assign tx_valid = !tx_empty;
  assign tx_byte  = tx_mem[tx_rd_ptr];
  assign rx_ready = !rx_full;

  // A full TX FIFO still accepts a write when the head leaves in the same cycle.
  assign tx_pop  = rdy && !tx_empty && tx_ready;
  assign tx_push = rdy && mem_wr && io_sel && (!tx_full || tx_pop);
  assign rx_push = rdy && rx_valid && !rx_full;
  assign rx_pop  = rdy && !mem_wr && io_sel && !rx_empty;

  always_comb begin
    tx_count_next = tx_count;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_next = tx_count + CNT_W'(1);
      2'b01:   tx_count_next = tx_count - CNT_W'(1);
      default: tx_count_next = tx_count;
    endcase
  end

  always_comb begin
    rx_count_next = rx_count;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_next = rx_count + CNT_W'(1);
      2'b01:   rx_count_next = rx_count - CNT_W'(1);
      default: rx_count_next = rx_count;
    endcase
  end

  // Storage arrays carry no reset; only pointers and counts define FIFO state.
  always_ff @(posedge clk) begin
    if (rdy && mem_wr && ram_sel) mem[ram_a] <= mem_dout;
    if (tx_push) tx_mem[tx_wr_ptr] <= mem_dout;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      tx_count <= tx_count_next;
      rx_count <= rx_count_next;
    end
  end

  // Registered outputs; the full threshold leaves room for one in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_din        <= 8'h00;
      io_buffer_full <= 1'b0;
      sim_halt       <= 1'b0;
    end else if (rdy) begin
      io_buffer_full <= ((DEPTH_C - tx_count_next) <= MARGIN_C);
      sim_halt       <= mem_wr && halt_sel;
      if (!mem_wr) begin
        if (io_sel)        mem_din <= rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
        else if (halt_sel) mem_din <= 8'h00;
        else               mem_din <= mem[ram_a];
      end
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder with queue-based scoreboards for
// read data and the TX byte stream.
module tb_ram_io_responder;

  localparam logic [31:0] IO_A   = 32'h0003_0000;
  localparam logic [31:0] HALT_A = 32'h0003_0004;

  logic        clk, rst_n, rdy;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout, mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_byte;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_ready, sim_halt;

  ram_io_responder dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .sim_halt(sim_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         tx_pend = 1'b0;
  logic [7:0] tx_pend_b = 8'h00;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: settle TX scoreboard for this cycle's inputs, then check read data.
  task automatic tick();
    int sz;
    bit pop_ok;
    logic [7:0] e;
    sz = tx_q.size();
    pop_ok = rst_n && rdy && tx_ready && (sz > 0);
    if (pop_ok) begin
      chk("tx_valid_at_pop", 8'(tx_valid), 8'h01);
      e = tx_q.pop_front();
      chk("tx_byte", tx_byte, e);
    end
    if (tx_pend) begin
      if (rdy && (sz < 8 || pop_ok)) tx_q.push_back(tx_pend_b);
      tx_pend = 1'b0;
    end
    @(negedge clk);
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      chk("mem_din", mem_din, e);
    end
  endtask

  task automatic idle();
    mem_a  = 32'h0;
    mem_wr = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_wr = 1'b1; mem_dout = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp);
    mem_a = a; mem_wr = 1'b0;
    rd_q.push_back(exp);
    tick();
    idle();
  endtask

  task automatic wr_io(input logic [7:0] d);
    mem_a = IO_A; mem_wr = 1'b1; mem_dout = d;
    tx_pend = 1'b1; tx_pend_b = d;
    tick();
    idle();
  endtask

  task automatic rd_io();
    logic [7:0] e;
    mem_a = IO_A; mem_wr = 1'b0;
    e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
    rd_q.push_back(e);
    tick();
    idle();
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    if (rx_q.size() < 8) rx_q.push_back(b);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && tx_q.size() > 0; i++) tick();
    vectors++;
    assert (tx_q.size() == 0) else begin
      miscompares++;
      $error("FAIL %s_timeout observed=%0d expected=0", tag, tx_q.size());
    end
    chk({tag, "_empty"}, 8'(tx_valid), 8'h00);
    tx_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
    tx_ready = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_full", 8'(io_buffer_full), 8'h00);
    chk("rst_tx_valid", 8'(tx_valid), 8'h00);
    chk("rst_rx_ready", 8'(rx_ready), 8'h01);
    chk("rst_halt", 8'(sim_halt), 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // RAM read/write, top address, upper-bit aliasing
    wr(32'h0001_0, 8'hA5);
    rd(32'h0001_0, 8'hA5);
    wr(32'h0001_FFFF, 8'h3C);
    rd(32'h0001_FFFF, 8'h3C);
    wr(32'h0000_0011, 8'h5A);
    rd(32'h0000_0010, 8'hA5);
    rd(32'h0000_0011, 8'h5A);
    rd(32'h0002_0010, 8'hA5);

    // TX back-pressure
    for (int i = 1; i <= 6; i++) begin
      wr_io(8'(i));
      if (i == 5) chk("full_after_5", 8'(io_buffer_full), 8'h00);
    end
    chk("full_after_6", 8'(io_buffer_full), 8'h01);
    chk("tx_head", tx_byte, 8'h01);
    tx_ready = 1'b1;
    tick();
    chk("full_after_pop", 8'(io_buffer_full), 8'h00);
    drain("drain1");

    // RX path
    rx_push(8'h41);
    rx_push(8'h42);
    rd_io(); rd_io(); rd_io(); rd_io();
    rx_push(8'h43);
    rd_io();
    for (int i = 0; i < 8; i++) rx_push(8'h50 + 8'(i));
    chk("rx_ready_full", 8'(rx_ready), 8'h00);
    rx_push(8'hEE);
    for (int i = 0; i < 9; i++) rd_io();
    chk("rx_ready_empty", 8'(rx_ready), 8'h01);

    // TX full + simultaneous push/pop across pointer wrap
    for (int i = 0; i < 8; i++) wr_io(8'h10 + 8'(i));
    chk("tx_full_flag", 8'(io_buffer_full), 8'h01);
    tx_ready = 1'b1;
    wr_io(8'h18);
    tx_ready = 1'b0;
    chk("full_simul", 8'(io_buffer_full), 8'h01);
    wr_io(8'h19);
    drain("drain2");

    // Halt strobe
    wr(HALT_A, 8'hFF);
    chk("halt_hi", 8'(sim_halt), 8'h01);
    tick();
    chk("halt_lo", 8'(sim_halt), 8'h00);
    chk("halt_no_push", 8'(tx_valid), 8'h00);
    rd(HALT_A, 8'h00);

    // rdy=0 freezes writes
    wr(32'h0000_0020, 8'h11);
    rdy = 1'b0;
    wr_io(8'h77);
    wr(32'h0000_0020, 8'h77);
    rdy = 1'b1;
    tick();
    chk("rdy0_no_push", 8'(tx_valid), 8'h00);
    rd(32'h0000_0020, 8'h11);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 7; i++) wr_io(8'h60 + 8'(i));
    chk("pre_rst_full", 8'(io_buffer_full), 8'h01);
    tx_ready = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_tx_valid", 8'(tx_valid), 8'h00);
    chk("async_full", 8'(io_buffer_full), 8'h00);
    tx_q.delete();
    tx_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_tx_valid", 8'(tx_valid), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
